// File: rtl/vdp18_pkg.sv
// Shared VDP18 types: display modes, VRAM access kinds, access-slot numbering,
// plus the per-mode slot schedule used by the VRAM fetch sequencer.
package vdp18_pkg;

    typedef enum logic [1:0] {
        OPMODE_GRAPH1 = 2'b00,
        OPMODE_GRAPH2 = 2'b01,
        OPMODE_MULTIC = 2'b10,
        OPMODE_TEXTM  = 2'b11
    } opmode_t;

    typedef enum logic [2:0] {
        AC_NONE = 3'd0,
        AC_PNT  = 3'd1,
        AC_PCT  = 3'd2,
        AC_PGT  = 3'd3,
        AC_CPU  = 3'd4,
        AC_REFR = 3'd5
    } access_t;

    typedef enum logic [1:0] {
        SL_0 = 2'd0,
        SL_1 = 2'd1,
        SL_2 = 2'd2,
        SL_3 = 2'd3
    } slot_t;

    // Pixel-clock enables per access slot; the sequencer only supports 2.
    localparam int SLOT_PIX = 2;

    // Access kind owned by a slot inside the fetch window. AC_CPU marks a slot
    // the CPU port (or refresh) may use.
    function automatic access_t slot_access(opmode_t mode, slot_t slot);
        access_t acc;
        acc = AC_CPU;
        case (mode)
            OPMODE_TEXTM: begin
                case (slot)
                    SL_0:    acc = AC_PNT;
                    SL_1:    acc = AC_PGT;
                    default: acc = AC_CPU;
                endcase
            end
            OPMODE_MULTIC: begin
                case (slot)
                    SL_0:    acc = AC_PNT;
                    SL_2:    acc = AC_PGT;
                    default: acc = AC_CPU;
                endcase
            end
            default: begin
                case (slot)
                    SL_0:    acc = AC_PNT;
                    SL_1:    acc = AC_PCT;
                    SL_2:    acc = AC_PGT;
                    default: acc = AC_CPU;
                endcase
            end
        endcase
        return acc;
    endfunction

    // Text mode cells are 6 pixels (3 slots); everything else, including the
    // CPU-only rhythm outside the fetch window, runs 4 slots per cell.
    function automatic slot_t slot_next(slot_t slot, opmode_t mode, logic fetch);
        slot_t nxt;
        if (fetch && mode == OPMODE_TEXTM && slot == SL_2)
            nxt = SL_0;
        else
            nxt = slot_t'(slot + 2'd1);
        return nxt;
    endfunction

endpackage

// File: rtl/vdp18_vram_addr_gen.sv
// Combinational VRAM address formation for every access kind the fetch
// sequencer can issue. Bit vectors use the VDP's [0:n] numbering (bit 0 = MSB).
module vdp18_vram_addr_gen
    import vdp18_pkg::*;
(
    input  access_t     access_i,
    input  opmode_t     mode_i,
    input  logic [0:3]  reg_ntb_i,
    input  logic [0:7]  reg_ctb_i,
    input  logic [0:2]  reg_pgb_i,
    input  logic [0:8]  num_line_i,
    input  logic [0:9]  pat_table_i,
    input  logic [0:7]  pat_name_i,
    input  logic [0:13] cpu_addr_i,
    input  logic [0:7]  rfsh_cnt_i,
    output logic [0:13] addr_o
);

    // Line bits 0 and 3 never take part in any table address.
    logic unused_line;
    assign unused_line = num_line_i[0] ^ num_line_i[3];

    // Field concatenations; every form is exactly 14 bits with no carries.
    always_comb begin
        addr_o = cpu_addr_i;
        case (access_i)
            AC_PNT: addr_o = {reg_ntb_i, pat_table_i};
            AC_PCT: begin
                if (mode_i == OPMODE_GRAPH2)
                    addr_o = {reg_ctb_i[0], num_line_i[1:2], pat_name_i, num_line_i[6:8]};
                else
                    addr_o = {reg_ctb_i, 1'b0, pat_name_i[0:4]};
            end
            AC_PGT: begin
                case (mode_i)
                    OPMODE_GRAPH2: addr_o = {reg_pgb_i[0], num_line_i[1:2], pat_name_i, num_line_i[6:8]};
                    OPMODE_MULTIC: addr_o = {reg_pgb_i, pat_name_i, num_line_i[4:6]};
                    default:       addr_o = {reg_pgb_i, pat_name_i, num_line_i[6:8]};
                endcase
            end
            AC_REFR: addr_o = {6'b000000, rfsh_cnt_i};
            default: addr_o = cpu_addr_i;
        endcase
    end

endmodule

// File: rtl/vdp18_vram_fetch.sv
// VRAM access sequencer: splits each character cell into two-enable access
// slots, issues PNT/PCT/PGT reads and hands the free slots to the CPU port.
// Optional build macro VDP18_RFSH_EN turns every 4th consecutive idle CPU
// slot into a DRAM refresh access.
//
// slot | meaning
// -----+-----------------------------------------------------------
// SL_0 | PNT (character boundary; opmode_i is sampled here)
// SL_1 | PCT in GRAPH1/2, PGT in TEXTM, CPU in MULTIC
// SL_2 | PGT in GRAPH1/2/MULTIC, CPU in TEXTM (last slot of a text cell)
// SL_3 | CPU
// Outside the fetch window every slot is a CPU slot.
module vdp18_vram_fetch
    import vdp18_pkg::*;
#(
    parameter int SLOT_PIX = vdp18_pkg::SLOT_PIX
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        clk_en_5m37_i,
    input  opmode_t     opmode_i,
    input  logic        fetch_en_i,
    input  logic [0:8]  num_line_i,
    input  logic [0:9]  pat_table_i,
    input  logic [0:7]  pat_name_i,
    input  logic [0:3]  reg_ntb_i,
    input  logic [0:7]  reg_ctb_i,
    input  logic [0:2]  reg_pgb_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [0:13] cpu_addr_i,
    output logic        cpu_ack_o,
    output access_t     access_type_o,
    output logic        clk_en_acc_o,
    output logic [0:13] vram_a_o,
    output logic        vram_we_o
);

    logic        phase_q;
    slot_t       slot_q;
    opmode_t     mode_q;
    logic        fetch_q;
    access_t     access_q, access_d;
    logic [0:13] addr_q, addr_d;
    logic        we_q, we_d;

    logic        first_en, last_en;
    slot_t       slot_eff;
    opmode_t     mode_eff;
    access_t     kind;
    logic        refresh_due;
    logic [0:7]  rfsh_cnt;

    assign first_en = clk_en_5m37_i && (phase_q == 1'b0);
    assign last_en  = clk_en_5m37_i && (phase_q == 1'(SLOT_PIX - 1));

    // Decide what the slot starting at this enable will do.
    always_comb begin
        slot_eff = (fetch_en_i && !fetch_q) ? SL_0 : slot_q;
        mode_eff = (slot_eff == SL_0) ? opmode_i : mode_q;
        kind     = fetch_en_i ? slot_access(mode_eff, slot_eff) : AC_CPU;
        access_d = kind;
        we_d     = 1'b0;
        if (kind == AC_CPU) begin
            if (cpu_req_i) begin
                access_d = AC_CPU;
                we_d     = cpu_we_i;
            end else if (refresh_due) begin
                access_d = AC_REFR;
            end else begin
                access_d = AC_NONE;
            end
        end
    end

    vdp18_vram_addr_gen u_addr_gen (
        .access_i    (access_d),
        .mode_i      (mode_eff),
        .reg_ntb_i   (reg_ntb_i),
        .reg_ctb_i   (reg_ctb_i),
        .reg_pgb_i   (reg_pgb_i),
        .num_line_i  (num_line_i),
        .pat_table_i (pat_table_i),
        .pat_name_i  (pat_name_i),
        .cpu_addr_i  (cpu_addr_i),
        .rfsh_cnt_i  (rfsh_cnt),
        .addr_o      (addr_d)
    );

    // Slot register: launch the access on the 1st enable, retire it on the 2nd.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q  <= 1'b0;
            slot_q   <= SL_0;
            mode_q   <= OPMODE_GRAPH1;
            fetch_q  <= 1'b0;
            access_q <= AC_NONE;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else if (first_en) begin
            phase_q  <= 1'b1;
            slot_q   <= slot_eff;
            mode_q   <= mode_eff;
            fetch_q  <= fetch_en_i;
            access_q <= access_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
        end else if (last_en) begin
            phase_q  <= 1'b0;
            slot_q   <= slot_next(slot_q, mode_q, fetch_q);
            we_q     <= 1'b0;
        end
    end

`ifdef VDP18_RFSH_EN
    logic [1:0] idle_q;
    logic [7:0] rfsh_q;

    assign refresh_due = (idle_q == 2'd3);
    assign rfsh_cnt    = rfsh_q;

    // Count consecutive idle CPU slots; the 4th one refreshes and bumps the row.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idle_q <= 2'd0;
            rfsh_q <= 8'd0;
        end else if (first_en && kind == AC_CPU) begin
            if (cpu_req_i) begin
                idle_q <= 2'd0;
            end else if (refresh_due) begin
                idle_q <= 2'd0;
                rfsh_q <= rfsh_q + 8'd1;
            end else begin
                idle_q <= idle_q + 2'd1;
            end
        end
    end
`else
    assign refresh_due = 1'b0;
    assign rfsh_cnt    = 8'h00;
`endif

    assign access_type_o = access_q;
    assign vram_a_o      = addr_q;
    assign vram_we_o     = we_q;
    assign clk_en_acc_o  = last_en && (access_q != AC_NONE);
    assign cpu_ack_o     = last_en && (access_q == AC_CPU);

endmodule

// File: tb/tb_vdp18_vram_fetch.sv
// Directed bench for the VRAM fetch sequencer. Pixel enables arrive every
// other clock; each slot is two enables. Build with VDP18_RFSH_EN defined to
// exercise the refresh variant.
module tb_vdp18_vram_fetch;
    import vdp18_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    opmode_t     opmode;
    logic        fetch_en;
    logic [0:8]  num_line;
    logic [0:9]  pat_table;
    logic [0:7]  pat_name;
    logic [0:3]  reg_ntb;
    logic [0:7]  reg_ctb;
    logic [0:2]  reg_pgb;
    logic        cpu_req;
    logic        cpu_we;
    logic [0:13] cpu_addr;
    logic        cpu_ack;
    access_t     access_type;
    logic        clk_en_acc;
    logic [0:13] vram_a;
    logic        vram_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vdp18_vram_fetch dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .clk_en_5m37_i (clk_en),
        .opmode_i      (opmode),
        .fetch_en_i    (fetch_en),
        .num_line_i    (num_line),
        .pat_table_i   (pat_table),
        .pat_name_i    (pat_name),
        .reg_ntb_i     (reg_ntb),
        .reg_ctb_i     (reg_ctb),
        .reg_pgb_i     (reg_pgb),
        .cpu_req_i     (cpu_req),
        .cpu_we_i      (cpu_we),
        .cpu_addr_i    (cpu_addr),
        .cpu_ack_o     (cpu_ack),
        .access_type_o (access_type),
        .clk_en_acc_o  (clk_en_acc),
        .vram_a_o      (vram_a),
        .vram_we_o     (vram_we)
    );

    task automatic apply_reset();
        rst_n = 1'b0; clk_en = 1'b0; fetch_en = 1'b0; opmode = OPMODE_GRAPH1;
        num_line = 9'd10; pat_table = 10'h005; pat_name = 8'h23;
        reg_ntb = 4'h1; reg_ctb = 8'hA5; reg_pgb = 3'b101;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 14'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One pixel enable; samples the combinational pulses during the enable cycle.
    task automatic pix(output logic acc, output logic ack, output logic we_mid);
        @(negedge clk);
        clk_en = 1'b1;
        #1;
        acc = clk_en_acc; ack = cpu_ack; we_mid = vram_we;
        @(negedge clk);
        clk_en = 1'b0;
    endtask

    // One full slot: registered outputs after the 1st enable, pulses on the 2nd.
    task automatic run_slot(output access_t t, output logic [0:13] a, output logic we1,
                            output logic acc1, output logic acc, output logic ack,
                            output logic we_mid, output logic we_after);
        logic ack1, wm1;
        pix(acc1, ack1, wm1);
        t = access_type; a = vram_a; we1 = vram_we;
        pix(acc, ack, we_mid);
        we_after = vram_we;
    endtask

    task automatic test_reset();
        logic acc, ack, wm;
        apply_reset();
        checks++;
        if (access_type !== AC_NONE || vram_a !== 14'h0 || vram_we !== 1'b0 || clk_en_acc !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++; $display("FAIL reset_init type=%s a=%h we=%b acc=%b ack=%b exp NONE/0/0/0/0", access_type.name(), vram_a, vram_we, clk_en_acc, cpu_ack);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2AAA;
        pix(acc, ack, wm);
        checks++;
        if (access_type !== AC_CPU || vram_a !== 14'h2AAA || vram_we !== 1'b1) begin
            errors++; $display("FAIL reset_pre type=%s a=%h we=%b exp CPU/2aaa/1", access_type.name(), vram_a, vram_we);
        end
        @(negedge clk);
        rst_n = 1'b0; clk_en = 1'b1;
        #1;
        checks++;
        if (access_type !== AC_NONE || vram_a !== 14'h0 || vram_we !== 1'b0 || clk_en_acc !== 1'b0 || cpu_ack !== 1'b0) begin
            errors++; $display("FAIL reset_mid type=%s a=%h we=%b acc=%b ack=%b exp NONE/0/0/0/0", access_type.name(), vram_a, vram_we, clk_en_acc, cpu_ack);
        end
        @(negedge clk); clk_en = 1'b0; cpu_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix(acc, ack, wm);
            checks++;
            if (ack !== 1'b0 || acc !== 1'b0) begin
                errors++; $display("FAIL reset_after en %0d ack=%b acc=%b exp 0/0", i, ack, acc);
            end
        end
    endtask

    task automatic test_graph1();
        access_t t, exp_t [4];
        logic [0:13] a, exp_a [3];
        logic we1, acc1, acc, ack, wm, wa;
        exp_t = '{AC_PNT, AC_PCT, AC_PGT, AC_NONE};
        exp_a = '{14'h0405, 14'h2944, 14'h291A};
        apply_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            checks++;
            if (t !== exp_t[i % 4]) begin
                errors++; $display("FAIL g1_type slot %0d got %s exp %s", i, t.name(), exp_t[i % 4].name());
            end
            if (i % 4 < 3) begin
                checks++;
                if (a !== exp_a[i % 4]) begin
                    errors++; $display("FAIL g1_addr slot %0d got %h exp %h", i, a, exp_a[i % 4]);
                end
            end
            checks++;
            if (acc1 !== 1'b0 || acc !== (i % 4 != 3) || ack !== 1'b0 || we1 !== 1'b0) begin
                errors++; $display("FAIL g1_pulse slot %0d acc1=%b acc=%b ack=%b we=%b exp 0/%b/0/0", i, acc1, acc, ack, we1, (i % 4 != 3));
            end
        end
    endtask

    task automatic test_graph2_multic();
        access_t t, exp_t [8];
        logic [0:13] a, exp_a [8];
        logic we1, acc1, acc, ack, wm, wa;
        exp_t = '{AC_PNT, AC_PCT, AC_PGT, AC_NONE, AC_PNT, AC_NONE, AC_PGT, AC_NONE};
        exp_a = '{14'h0405, 14'h3918, 14'h1918, 14'h0, 14'h0405, 14'h0, 14'h191A, 14'h0};
        apply_reset();
        num_line = 9'd200; reg_pgb = 3'b011; opmode = OPMODE_GRAPH2; fetch_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) opmode = OPMODE_MULTIC;
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            checks++;
            if (t !== exp_t[i]) begin
                errors++; $display("FAIL g2mc_type slot %0d got %s exp %s", i, t.name(), exp_t[i].name());
            end
            if (exp_t[i] != AC_NONE) begin
                checks++;
                if (a !== exp_a[i]) begin
                    errors++; $display("FAIL g2mc_addr slot %0d got %h exp %h", i, a, exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_textm();
        access_t t, exp_t [3];
        logic [0:13] a;
        logic we1, acc1, acc, ack, wm, wa;
        exp_t = '{AC_PNT, AC_PGT, AC_NONE};
        apply_reset();
        opmode = OPMODE_TEXTM; fetch_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            checks++;
            if (t !== exp_t[i % 3] || t === AC_PCT) begin
                errors++; $display("FAIL txt_type slot %0d got %s exp %s", i, t.name(), exp_t[i % 3].name());
            end
            if (i % 3 == 1) begin
                checks++;
                if (a !== 14'h291A) begin
                    errors++; $display("FAIL txt_pgt slot %0d got %h exp 291a", i, a);
                end
            end
        end
    endtask

    task automatic test_cpu_write();
        access_t t;
        logic [0:13] a;
        logic we1, acc1, acc, ack, wm, wa;
        apply_reset();
        fetch_en = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2AAA;
        for (int i = 0; i < 3; i++) begin
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            checks++;
            if (we1 !== 1'b0 || wm !== 1'b0 || ack !== 1'b0 || acc !== 1'b1) begin
                errors++; $display("FAIL wr_fetch slot %0d we=%b/%b ack=%b acc=%b exp 0/0/0/1", i, we1, wm, ack, acc);
            end
        end
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        cpu_req = 1'b0;
        checks++;
        if (t !== AC_CPU || a !== 14'h2AAA || we1 !== 1'b1 || wm !== 1'b1) begin
            errors++; $display("FAIL wr_cpu type=%s a=%h we=%b/%b exp CPU/2aaa/1/1", t.name(), a, we1, wm);
        end
        checks++;
        if (ack !== 1'b1 || acc !== 1'b1 || wa !== 1'b0) begin
            errors++; $display("FAIL wr_ack ack=%b acc=%b we_after=%b exp 1/1/0", ack, acc, wa);
        end
    endtask

    task automatic test_back_to_back();
        access_t t;
        logic [0:13] a;
        logic we1, acc1, acc, ack, wm, wa;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        checks++;
        if (t !== AC_CPU || a !== 14'h1234 || we1 !== 1'b0 || ack !== 1'b1) begin
            errors++; $display("FAIL b2b_first type=%s a=%h we=%b ack=%b exp CPU/1234/0/1", t.name(), a, we1, ack);
        end
        cpu_addr = 14'h0F0F;
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        cpu_req = 1'b0;
        checks++;
        if (t !== AC_CPU || a !== 14'h0F0F || ack !== 1'b1) begin
            errors++; $display("FAIL b2b_second type=%s a=%h ack=%b exp CPU/0f0f/1", t.name(), a, ack);
        end
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        checks++;
        if (t !== AC_NONE || ack !== 1'b0 || acc !== 1'b0) begin
            errors++; $display("FAIL b2b_idle type=%s ack=%b acc=%b exp NONE/0/0", t.name(), ack, acc);
        end
    endtask

    task automatic test_fetch_fall();
        access_t t;
        logic [0:13] a;
        logic we1, acc1, acc, ack, wm, wa, ack1;
        apply_reset();
        fetch_en = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2AAA;
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        pix(acc1, ack1, wm);
        checks++;
        if (access_type !== AC_PCT || vram_a !== 14'h2944) begin
            errors++; $display("FAIL ff_pct type=%s a=%h exp PCT/2944", access_type.name(), vram_a);
        end
        fetch_en = 1'b0;
        pix(acc, ack, wm);
        checks++;
        if (acc !== 1'b1 || ack !== 1'b0) begin
            errors++; $display("FAIL ff_pct_done acc=%b ack=%b exp 1/0", acc, ack);
        end
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        cpu_req = 1'b0;
        checks++;
        if (t !== AC_CPU || a !== 14'h2AAA || ack !== 1'b1) begin
            errors++; $display("FAIL ff_cpu type=%s a=%h ack=%b exp CPU/2aaa/1", t.name(), a, ack);
        end
        run_slot(t, a, we1, acc1, acc, ack, wm, wa);
        checks++;
        if (t !== AC_NONE) begin
            errors++; $display("FAIL ff_idle type=%s exp NONE", t.name());
        end
    endtask

    task automatic test_mode_change();
        access_t t, exp_t [8];
        logic [0:13] a;
        logic we1, acc1, acc, ack, wm, wa;
        exp_t = '{AC_PNT, AC_PCT, AC_PGT, AC_NONE, AC_PNT, AC_PGT, AC_NONE, AC_PNT};
        apply_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) opmode = OPMODE_TEXTM;
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            checks++;
            if (t !== exp_t[i]) begin
                errors++; $display("FAIL mode_chg slot %0d got %s exp %s", i, t.name(), exp_t[i].name());
            end
        end
    endtask

    task automatic test_idle_refresh();
        access_t t;
        logic [0:13] a;
        logic we1, acc1, acc, ack, wm, wa;
        apply_reset();
`ifdef VDP18_RFSH_EN
        for (int k = 0; k < 1032; k++) begin
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            if (k % 4 == 3) begin
                checks++;
                if (t !== AC_REFR || a !== {6'b0, 8'((k / 4) % 256)} || acc !== 1'b1 || ack !== 1'b0) begin
                    errors++; $display("FAIL rfsh slot %0d type=%s a=%h acc=%b ack=%b exp REFR/%h/1/0", k, t.name(), a, acc, ack, 8'((k / 4) % 256));
                end
            end else begin
                checks++;
                if (t !== AC_NONE || acc !== 1'b0) begin
                    errors++; $display("FAIL rfsh_idle slot %0d type=%s acc=%b exp NONE/0", k, t.name(), acc);
                end
            end
        end
`else
        for (int k = 0; k < 8; k++) begin
            run_slot(t, a, we1, acc1, acc, ack, wm, wa);
            checks++;
            if (t !== AC_NONE || acc !== 1'b0 || ack !== 1'b0) begin
                errors++; $display("FAIL idle slot %0d type=%s acc=%b ack=%b exp NONE/0/0", k, t.name(), acc, ack);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_graph1();
        test_graph2_multic();
        test_textm();
        test_cpu_write();
        test_back_to_back();
        test_fetch_fall();
        test_mode_change();
        test_idle_refresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
